// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR filter.
//   state_t      - controller states (IDLE, MAC)
//   DEF_*        - default parameter values
//   chw_f/ow_f/aw_f - derived width helpers (channel tag, output, tap index)
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  localparam int unsigned DEF_DWIDTH = 15;
  localparam int unsigned DEF_CWIDTH = 11;
  localparam int unsigned DEF_NTAPS  = 37;
  localparam int unsigned DEF_NCH    = 2;

  // Channel tag width, never narrower than one bit.
  function automatic int unsigned chw_f(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Full-precision accumulator width: product bits plus growth for NTAPS terms.
  function automatic int unsigned ow_f(input int unsigned dw, input int unsigned cw,
                                       input int unsigned nt);
    return dw + cw + $clog2(nt);
  endfunction

  // Tap index / pointer width.
  function automatic int unsigned aw_f(input int unsigned nt);
    return (nt > 1) ? $clog2(nt) : 1;
  endfunction

endpackage

// File: rtl/fir_tdm_if.sv
// fir_tdm_if: bus bundle of the FIR filter.
//   EN, clear           - enable and synchronous history flush
//   din/din_ch/din_valid/din_ready - sample handshake
//   coeff_we/coeff_addr/coeff_wdata - coefficient write port
//   dout/dout_ch/dout_valid, err    - results and illegal-channel pulse
// slave modport faces the filter, master modport faces the user.
interface fir_tdm_if import fir_pkg::*; #(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned CWIDTH = DEF_CWIDTH,
  parameter int unsigned NTAPS  = DEF_NTAPS,
  parameter int unsigned NCH    = DEF_NCH
);
  localparam int unsigned CHW    = chw_f(NCH);
  localparam int unsigned OWIDTH = ow_f(DWIDTH, CWIDTH, NTAPS);
  localparam int unsigned AW     = aw_f(NTAPS);

  logic                      EN;
  logic                      clear;
  logic signed [DWIDTH-1:0]  din;
  logic [CHW-1:0]            din_ch;
  logic                      din_valid;
  logic                      din_ready;
  logic                      coeff_we;
  logic [AW-1:0]             coeff_addr;
  logic signed [CWIDTH-1:0]  coeff_wdata;
  logic signed [OWIDTH-1:0]  dout;
  logic [CHW-1:0]            dout_ch;
  logic                      dout_valid;
  logic                      err;

  modport slave (
    input  EN, clear, din, din_ch, din_valid, coeff_we, coeff_addr, coeff_wdata,
    output din_ready, dout, dout_ch, dout_valid, err
  );

  modport master (
    output EN, clear, din, din_ch, din_valid, coeff_we, coeff_addr, coeff_wdata,
    input  din_ready, dout, dout_ch, dout_valid, err
  );

endinterface

// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: shared signed multiply-accumulate unit.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero the accumulator (start of a pass)
//   add        - accumulate x*c this cycle
//   load       - register acc + x*c into result (last tap of a pass)
//   x, c       - sample and coefficient operands
//   result     - full-precision filter output, held between loads
module fir_tdm_mac #(
  parameter int unsigned DWIDTH = 15,
  parameter int unsigned CWIDTH = 11,
  parameter int unsigned OWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add,
  input  logic                     load,
  input  logic signed [DWIDTH-1:0] x,
  input  logic signed [CWIDTH-1:0] c,
  output logic signed [OWIDTH-1:0] result
);
  localparam int unsigned PW = DWIDTH + CWIDTH;

  logic signed [PW-1:0]     prod;
  logic signed [OWIDTH-1:0] acc;
  logic signed [OWIDTH-1:0] sum;

  always_comb begin
    prod = PW'(x) * PW'(c);
    sum  = acc + OWIDTH'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (add)
        acc <= sum;
      // The last tap goes straight into the result register, so the
      // accumulator itself never needs to hold the final sum.
      if (load)
        result <= sum;
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed multi-channel FIR filter.
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - fir_tdm_if.slave: sample handshake, coefficient port, results
// One MAC pass of NTAPS cycles runs per accepted sample; the coefficient set
// is shared by all channels, each channel keeps a circular sample history.
module fir_tdm import fir_pkg::*; #(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned CWIDTH = DEF_CWIDTH,
  parameter int unsigned NTAPS  = DEF_NTAPS,
  parameter int unsigned NCH    = DEF_NCH
) (
  input logic     CLK,
  input logic     RST,
  fir_tdm_if.slave bus
);
  localparam int unsigned CHW    = chw_f(NCH);
  localparam int unsigned OWIDTH = ow_f(DWIDTH, CWIDTH, NTAPS);
  localparam int unsigned AW     = aw_f(NTAPS);
  localparam logic [AW-1:0]  LAST  = AW'(NTAPS - 1);
  localparam logic [CHW:0]   NCH_W = (CHW + 1)'(NCH);

  state_t                    state;
  logic                      live;
  logic [CHW-1:0]            ch_q;
  logic [AW-1:0]             k;
  logic [AW-1:0]             wptr [NCH];
  logic signed [DWIDTH-1:0]  hist [NCH][NTAPS];
  logic signed [CWIDTH-1:0]  coef [NTAPS];

  logic                      take;
  logic                      bad_ch;
  logic                      start;
  logic                      mac_add;
  logic                      mac_load;
  logic [AW-1:0]             wptr_nxt;
  logic [AW-1:0]             rptr;
  logic [AW-1:0]             idx;

  // live holds din_ready low for as long as reset is applied.
  assign bus.din_ready = live & bus.EN & (state == IDLE);

  always_comb begin
    take     = bus.din_valid & bus.din_ready & ~bus.clear;
    bad_ch   = ({1'b0, bus.din_ch} >= NCH_W);
    start    = take & ~bad_ch;
    mac_add  = (state == MAC) & ~bus.clear;
    mac_load = mac_add & (k == LAST);
    wptr_nxt = '0;
    if (!bad_ch)
      wptr_nxt = (wptr[bus.din_ch] == LAST) ? '0 : wptr[bus.din_ch] + 1'b1;
    // (rptr - k) mod NTAPS without a wider intermediate: LAST - k never
    // underflows, and the wrapped sum stays below NTAPS.
    rptr = wptr[ch_q];
    if (rptr >= k)
      idx = rptr - k;
    else
      idx = rptr + (LAST - k) + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      live           <= 1'b0;
      ch_q           <= '0;
      k              <= '0;
      wptr           <= '{default: '0};
      hist           <= '{default: '{default: '0}};
      coef           <= '{default: '0};
      bus.dout_ch    <= '0;
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      live           <= 1'b1;
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;

      if (state == IDLE && bus.coeff_we && bus.coeff_addr <= LAST)
        coef[bus.coeff_addr] <= bus.coeff_wdata;

      if (bus.clear) begin
        wptr  <= '{default: '0};
        hist  <= '{default: '{default: '0}};
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (take) begin
              if (bad_ch) begin
                bus.err <= 1'b1;
              end else begin
                hist[bus.din_ch][wptr_nxt] <= bus.din;
                wptr[bus.din_ch]           <= wptr_nxt;
                ch_q                       <= bus.din_ch;
                k                          <= '0;
                state                      <= MAC;
              end
            end
          end
          MAC: begin
            if (k == LAST) begin
              bus.dout_ch    <= ch_q;
              bus.dout_valid <= 1'b1;
              state          <= IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fir_tdm_mac #(
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH),
    .OWIDTH (OWIDTH)
  ) u_mac (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (start),
    .add    (mac_add),
    .load   (mac_load),
    .x      (hist[ch_q][idx]),
    .c      (coef[k]),
    .result (bus.dout)
  );

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: self-checking bench for fir_tdm (three channels, 37 taps).
module tb_fir_tdm;
  localparam int DWIDTH = 15;
  localparam int CWIDTH = 11;
  localparam int NTAPS  = 37;
  localparam int NCH    = 3;
  localparam int CHW    = 2;
  localparam int AW     = 6;

  typedef struct {
    bit     clr;
    int     ch;
    int     din;
    longint exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fir_tdm_if #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .NTAPS(NTAPS), .NCH(NCH)) bus ();

  fir_tdm #(.DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .NTAPS(NTAPS), .NCH(NCH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int half [19] = '{144, 115, 158, 207, -60, -233, -180, 95, 310, 260,
                    -120, -400, -350, 180, 620, 700, 850, 980, 1000};
  int c_tab [NTAPS];
  int mc [NTAPS];
  int mh [NCH][NTAPS];
  vec_t vt [$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: newest sample at index 0, y = sum c[k]*x[n-k].
  function automatic longint model_push(input int ch, input int v);
    longint s = 0;
    for (int i = NTAPS - 1; i > 0; i--) mh[ch][i] = mh[ch][i-1];
    mh[ch][0] = v;
    for (int j = 0; j < NTAPS; j++) s += longint'(mc[j]) * longint'(mh[ch][j]);
    return s;
  endfunction

  task automatic load_coefs(input int arr [NTAPS]);
    for (int i = 0; i < NTAPS; i++) begin
      bus.coeff_we    = 1'b1;
      bus.coeff_addr  = AW'(i);
      bus.coeff_wdata = CWIDTH'(arr[i]);
      tick();
    end
    bus.coeff_we = 1'b0;
    mc = arr;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) mh[c][i] = 0;
  endtask

  task automatic launch(input int ch, input int val);
    int w = 0;
    while (!bus.din_ready && w < 100) begin tick(); w++; end
    chk("din_ready before accept", longint'(bus.din_ready), 1);
    bus.din       = DWIDTH'(val);
    bus.din_ch    = CHW'(ch);
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int start, input int ch, input longint exp);
    int lat = start;
    while (!bus.dout_valid && lat < 100) begin tick(); lat++; end
    chk({name, " latency"}, lat, NTAPS);
    chk({name, " dout"}, longint'(bus.dout), exp);
    chk({name, " dout_ch"}, longint'(bus.dout_ch), ch);
    tick();
    chk({name, " pulse width"}, longint'(bus.dout_valid), 0);
  endtask

  task automatic quiet(input string name, input int n);
    int seen = 0;
    repeat (n) begin tick(); if (bus.dout_valid) seen++; end
    chk(name, seen, 0);
  endtask

  initial begin
    int rc [NTAPS];
    longint sum0;
    bus.EN = 1'b1; bus.clear = 1'b0; bus.din = '0; bus.din_ch = '0; bus.din_valid = 1'b0;
    bus.coeff_we = 1'b0; bus.coeff_addr = '0; bus.coeff_wdata = '0;
    for (int i = 0; i < 19; i++) begin c_tab[i] = half[i]; c_tab[NTAPS-1-i] = half[i]; end

    // Reset state
    #1 RST = 1'b0;
    #2;
    chk("reset din_ready", longint'(bus.din_ready), 0);
    chk("reset dout", longint'(bus.dout), 0);
    chk("reset dout_valid", longint'(bus.dout_valid), 0);
    chk("reset err", longint'(bus.err), 0);
    chk("reset dout_ch", longint'(bus.dout_ch), 0);
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("din_ready after reset", longint'(bus.din_ready), 1);

    // Table: impulse response on ch0, then ch1 impulse interleaved with ch0 constant
    load_coefs(c_tab);
    for (int n = 0; n < NTAPS; n++)
      vt.push_back('{clr: 1'b0, ch: 0, din: (n == 0) ? 1 : 0, exp: longint'(c_tab[n])});
    sum0 = 0;
    for (int n = 0; n < NTAPS; n++) begin
      sum0 += c_tab[n];
      vt.push_back('{clr: (n == 0), ch: 1, din: (n == 0) ? 1 : 0, exp: longint'(c_tab[n])});
      vt.push_back('{clr: 1'b0, ch: 0, din: 100, exp: 100 * sum0});
    end
    foreach (vt[i]) begin
      if (vt[i].clr) pulse_clear();
      launch(vt[i].ch, vt[i].din);
      wait_out($sformatf("vec%0d", i), 0, vt[i].ch, vt[i].exp);
    end

    // Full-scale negative
    for (int i = 0; i < NTAPS; i++) rc[i] = -1024;
    load_coefs(rc);
    pulse_clear();
    for (int n = 0; n < NTAPS; n++) begin
      launch(0, -16384);
      wait_out($sformatf("fullscale%0d", n), 0, 0, longint'(n + 1) * 16777216);
    end

    // Randomized against the reference model
    for (int i = 0; i < NTAPS; i++) rc[i] = int'($urandom_range(0, 2047)) - 1024;
    load_coefs(rc);
    pulse_clear();
    for (int n = 0; n < 40; n++) begin
      int ch, v;
      longint e;
      ch = int'($urandom_range(0, NCH - 1));
      v  = int'($urandom_range(0, 32767)) - 16384;
      e  = model_push(ch, v);
      launch(ch, v);
      wait_out($sformatf("rand%0d", n), 0, ch, e);
    end

    // Coefficient writes during MAC are lost
    load_coefs(c_tab);
    pulse_clear();
    launch(0, 1);
    repeat (5) tick();
    bus.coeff_we = 1'b1; bus.coeff_addr = AW'(0); bus.coeff_wdata = CWIDTH'(7);
    tick();
    bus.coeff_we = 1'b0;
    wait_out("cw pass1", 6, 0, 144);
    launch(0, 3);
    bus.coeff_we = 1'b1; bus.coeff_addr = AW'(1); bus.coeff_wdata = -CWIDTH'(5);
    tick();
    bus.coeff_we = 1'b0;
    wait_out("cw old coef", 1, 0, 3 * 144 + 115);
    pulse_clear();
    launch(0, 1);
    wait_out("cw addr0 lost", 0, 0, 144);
    launch(0, 0);
    wait_out("cw addr1 lost", 0, 0, 115);

    // Illegal channel tag
    bus.din = DWIDTH'(500); bus.din_ch = CHW'(NCH); bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    chk("illegal err pulse", longint'(bus.err), 1);
    chk("illegal stays idle", longint'(bus.din_ready), 1);
    tick();
    chk("illegal err one cycle", longint'(bus.err), 0);
    quiet("illegal no dout_valid", 45);

    // Clear mid-pass aborts, next impulse gives c[0] exactly
    launch(0, 5);
    repeat (10) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    quiet("clear aborts pass", 45);
    launch(0, 1);
    wait_out("after clear", 0, 0, 144);

    // EN low: in-flight pass completes, no new accepts
    launch(0, 2);
    repeat (3) tick();
    bus.EN = 1'b0;
    tick();
    chk("EN low din_ready in MAC", longint'(bus.din_ready), 0);
    wait_out("EN low pass", 4, 0, 2 * 144 + 115);
    chk("EN low din_ready idle", longint'(bus.din_ready), 0);
    bus.din = DWIDTH'(9); bus.din_ch = '0; bus.din_valid = 1'b1;
    repeat (5) tick();
    bus.din_valid = 1'b0;
    quiet("EN low no accept", 45);
    bus.EN = 1'b1;

    // Reset mid-pass
    launch(0, 7);
    repeat (10) tick();
    #2 RST = 1'b0;
    #1;
    chk("midreset dout", longint'(bus.dout), 0);
    chk("midreset dout_valid", longint'(bus.dout_valid), 0);
    chk("midreset din_ready", longint'(bus.din_ready), 0);
    chk("midreset err", longint'(bus.err), 0);
    chk("midreset dout_ch", longint'(bus.dout_ch), 0);
    tick();
    RST = 1'b1;
    quiet("midreset no dout_valid", 45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tdm.md
# fir_tdm

Parametrised, time-multiplexed multi-channel FIR filter: one shared signed multiply-accumulate unit serves NCH independent channels, each with its own NTAPS-deep sample history. Coefficients are run-time loadable through a write port. Samples enter through a valid/ready handshake. Results leave as full-precision one-cycle pulses tagged with their channel. It replaces the fixed parallel-array FIR in the receive filter chain wherever sample rate is far below CLK.

## Interface
- DWIDTH, 15: sample width, signed two's complement.
- CWIDTH, 11: coefficient width, signed two's complement.
- NTAPS, 37: taps per channel, ≥ 2.
- NCH, 2: channel count, ≥ 1.
- CHW, $clog2(NCH) (min 1): channel-tag width, derived.
- OWIDTH, DWIDTH+CWIDTH+$clog2(NTAPS): output width, derived.

Ports:
- CLK  in  1  single system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  enable; gates din_ready.
- clear  in  1  synchronous flush of every channel's history.
- din  in  DWIDTH  input sample.
- din_ch  in  CHW  channel tag of din.
- din_valid  in  1  sample present.
- din_ready  out  1  block can accept a sample.
- coeff_we  in  1  coefficient write strobe.
- coeff_addr  in  $clog2(NTAPS)  tap index k.
- coeff_wdata  in  CWIDTH  coefficient value.
- dout  out  OWIDTH  filter result, held between pulses.
- dout_ch  out  CHW  channel tag of dout.
- dout_valid  out  1  one-cycle result strobe.
- err  out  1  one-cycle pulse on an illegal channel tag.

## Operation
- Result: y_ch[n] = Σ_{k=0..NTAPS-1} c[k]·x_ch[n-k], exact signed arithmetic.
  - Products are CWIDTH+DWIDTH bits.
  - Accumulator is OWIDTH bits, sign-extended; no rounding or saturation.
- The coefficient set c[] is shared by all channels.
- Each channel's history is a circular buffer of NTAPS entries with its own write pointer.
  - Pointers wrap from NTAPS-1 to 0.
  - Tap k reads entry (wptr − k) mod NTAPS.
- FSM has two states, IDLE and MAC.
  - IDLE: din_ready = EN.
  - Accept (din_valid & din_ready):
    - write din into the buffer of din_ch;
    - advance that channel's pointer;
    - latch the channel;
    - clear the accumulator and set k = 0;
    - go to MAC.
  - MAC: din_ready = 0. Each cycle adds c[k]·x[wptr−k] and increments k.
  - After tap NTAPS-1: load dout and dout_ch, pulse dout_valid, return to IDLE.
- EN low has no effect on a MAC pass already in progress; that pass completes.
- Illegal channel tag (din_ch ≥ NCH, accepted in IDLE):
  - no buffer write and no MAC pass;
  - err pulses the next cycle;
  - the block stays in IDLE.
- Coefficient writes:
  - take effect only in IDLE, and only with coeff_addr < NTAPS;
  - are silently ignored in all other cases.
- clear:
  - in IDLE: zeros all histories; pointers return to 0;
  - in MAC: additionally aborts the pass with no dout_valid; state returns to IDLE.
- Reset values:
  - din_ready=0, dout=0, dout_ch=0, dout_valid=0, err=0;
  - all histories, pointers and coefficients 0;
  - state IDLE.

## Timing
- Accept edge E0. Taps 0..NTAPS-1 accumulate on edges E1..E_NTAPS.
- dout/dout_valid are registered at E_NTAPS; latency is NTAPS cycles.
- din_ready is high again in the cycle after E_NTAPS, so the earliest next accept is E_{NTAPS+1}.
- Peak throughput is one sample per NTAPS+1 cycles, summed over all channels.
- A coeff_we in the same IDLE cycle as an accept is applied before the MAC pass begins.
- clear takes priority over an accept in the same cycle; the sample is dropped.
- RST asserted mid-pass:
  - the pass is discarded immediately;
  - all outputs go to their reset values asynchronously;
  - no dout_valid pulse follows.
- dout holds its last value and is meaningful only while dout_valid=1.

## Structure
- Package fir_pkg:
  - state enum (IDLE, MAC);
  - width helper functions for CHW and OWIDTH;
  - default parameter constants.
- Sub-module fir_tdm_mac:
  - signed multiplier plus accumulator with clear and load-result controls;
  - top level keeps the FSM, circular buffers and coefficient register file.

## Test plan
- Impulse response:
  - stimulus: load c = 144,115,158,…,115,144 (37 taps); send din=1 then 36 zeros, all on ch0;
  - required: dout = 144,115,158,207,… in order; each dout_valid exactly 37 cycles after its accept.
- Channel isolation:
  - stimulus: impulse on ch1 interleaved with constant 100 on ch0;
  - required: ch1 reproduces c[k]; ch0 settles to 100·Σc; every dout_ch is correct.
- Full-scale negative:
  - stimulus: all c = −1024, din = −16384 repeatedly on ch0;
  - required: after 37 samples dout = 620756992, with no overflow.
- Coefficient write during MAC:
  - stimulus: coeff_we mid-pass;
  - required: the result uses the old coefficient, and the write is lost.
- Illegal channel and clear:
  - stimulus: din_ch=NCH → required: err pulse, no dout_valid;
  - stimulus: clear mid-pass → required: no dout_valid, and the next impulse gives c[0] exactly.
- Reset and EN:
  - stimulus: RST low mid-pass → required: all outputs 0 immediately;
  - stimulus: EN low → required: din_ready=0, and the in-flight pass still completes.
